// File: rtl/spram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port "No_change" RAM,
// with optional zero-fill after reset. Define SPRAM_ARB_STATS_EN for grant/conflict counters.
module spram_arbiter #(
  parameter int depth        = 64,
  parameter int width        = 8,
  parameter bit clear_on_rst = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  input  logic                     a_we,
  input  logic [$clog2(depth)-1:0] a_addr,
  input  logic [width-1:0]         a_wdata,
  output logic                     a_ready,
  output logic                     a_rvalid,
  output logic [width-1:0]         a_rdata,
  input  logic                     b_valid,
  input  logic                     b_we,
  input  logic [$clog2(depth)-1:0] b_addr,
  input  logic [width-1:0]         b_wdata,
  output logic                     b_ready,
  output logic                     b_rvalid,
  output logic [width-1:0]         b_rdata,
  output logic                     ram_wr_en,
  output logic [$clog2(depth)-1:0] ram_addr,
  output logic [width-1:0]         ram_din,
  input  logic [width-1:0]         ram_dout,
`ifdef SPRAM_ARB_STATS_EN
  output logic [15:0]              a_gnt_cnt,
  output logic [15:0]              b_gnt_cnt,
  output logic [15:0]              conflict_cnt,
`endif
  output logic                     busy
);
  localparam int AW = $clog2(depth);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic             rr_ptr_q, rr_ptr_d;        // 0 = A has priority, 1 = B
  logic             rd_tag_v_q, rd_tag_v_d;
  logic             rd_tag_port_q, rd_tag_port_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [width-1:0] din_q, din_d;
  logic             gnt, gnt_b;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    rd_tag_v_d    = 1'b0;
    rd_tag_port_d = rd_tag_port_q;
    addr_d        = addr_q;
    din_d         = din_q;
    a_ready       = 1'b0;
    b_ready       = 1'b0;
    ram_wr_en     = 1'b0;
    ram_addr      = addr_q;
    ram_din       = din_q;
    busy          = 1'b0;
    gnt           = 1'b0;
    gnt_b         = 1'b0;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        ram_wr_en = 1'b1;
        ram_addr  = clr_cnt_q;
        ram_din   = '0;
        addr_d    = clr_cnt_q;
        din_d     = '0;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(depth - 1)) state_d = RUN;
      end
      default: begin
        gnt   = a_valid | b_valid;
        gnt_b = b_valid & (~a_valid | rr_ptr_q);
        if (gnt) begin
          a_ready       = ~gnt_b;
          b_ready       = gnt_b;
          ram_wr_en     = gnt_b ? b_we    : a_we;
          ram_addr      = gnt_b ? b_addr  : a_addr;
          ram_din       = gnt_b ? b_wdata : a_wdata;
          addr_d        = ram_addr;
          din_d         = ram_din;
          rr_ptr_d      = ~gnt_b;
          rd_tag_v_d    = ~ram_wr_en;
          rd_tag_port_d = gnt_b;
        end
      end
    endcase
    // Reset overrides the outputs in the same cycle so the RAM sees no stray access.
    if (rst) begin
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      ram_wr_en = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
      busy      = clear_on_rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= clear_on_rst ? CLEAR : RUN;
      clr_cnt_q     <= '0;
      rr_ptr_q      <= 1'b0;
      rd_tag_v_q    <= 1'b0;
      rd_tag_port_q <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      rd_tag_v_q    <= rd_tag_v_d;
      rd_tag_port_q <= rd_tag_port_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
    end
  end

  assign a_rvalid = rd_tag_v_q & ~rd_tag_port_q & ~rst;
  assign b_rvalid = rd_tag_v_q &  rd_tag_port_q & ~rst;
  assign a_rdata  = a_rvalid ? ram_dout : '0;
  assign b_rdata  = b_rvalid ? ram_dout : '0;

`ifdef SPRAM_ARB_STATS_EN
  logic [15:0] a_gnt_q, b_gnt_q, conf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_gnt_q <= '0;
      b_gnt_q <= '0;
      conf_q  <= '0;
    end else begin
      if (a_valid && a_ready && a_gnt_q != 16'hFFFF) a_gnt_q <= a_gnt_q + 16'd1;
      if (b_valid && b_ready && b_gnt_q != 16'hFFFF) b_gnt_q <= b_gnt_q + 16'd1;
      if (state_q == RUN && a_valid && b_valid && conf_q != 16'hFFFF) conf_q <= conf_q + 16'd1;
    end
  end

  assign a_gnt_cnt    = a_gnt_q;
  assign b_gnt_cnt    = b_gnt_q;
  assign conflict_cnt = conf_q;
`endif
endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural No_change single-port RAM.
module tb_spram_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
  logic [5:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic       a_ready, a_rvalid, b_ready, b_rvalid, ram_wr_en, busy;
  logic [7:0] a_rdata, b_rdata, ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic [5:0] ram_addr;
`ifdef SPRAM_ARB_STATS_EN
  logic [15:0] a_gnt_cnt, b_gnt_cnt, conflict_cnt;
`endif
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [64];

  always #5 clk = ~clk;

  spram_arbiter #(.depth(64), .width(8), .clear_on_rst(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
`ifdef SPRAM_ARB_STATS_EN
    .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt), .conflict_cnt(conflict_cnt),
`endif
    .busy(busy)
  );

  // No_change RAM: output register holds during writes.
  initial for (int i = 0; i < 64; i++) mem[i] = 8'hA5 ^ 8'(i);
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_din;
    else           ram_dout <= mem[ram_addr];
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got a=%b b=%b exp 0 0", a_ready, b_ready); end
    checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got a=%b b=%b exp 0 0", a_rvalid, b_rvalid); end
    checks++; if (a_rdata !== 8'h00 || b_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got a=%h b=%h exp 00 00", a_rdata, b_rdata); end
    checks++; if (ram_wr_en !== 1'b0 || ram_addr !== 6'd0 || ram_din !== 8'h00) begin errors++; $display("FAIL rst_ram got we=%b addr=%0d din=%h exp 0 0 00", ram_wr_en, ram_addr, ram_din); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", busy); end
    tick();
  endtask

  task automatic test_clear_then_read;
    rst = 1'b0; a_valid = 1'b1; a_we = 1'b0; a_addr = 6'd5;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL clear_busy[%0d] got busy=%b a_ready=%b exp 1 0", i, busy, a_ready); end
      checks++; if (ram_wr_en !== 1'b1 || ram_addr !== 6'(i) || ram_din !== 8'h00) begin errors++; $display("FAIL clear_ram[%0d] got we=%b addr=%0d din=%h exp 1 %0d 00", i, ram_wr_en, ram_addr, ram_din, i); end
      tick();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || a_ready !== 1'b1) begin errors++; $display("FAIL run_grant got busy=%b a_ready=%b exp 0 1", busy, a_ready); end
    checks++; if (ram_wr_en !== 1'b0 || ram_addr !== 6'd5) begin errors++; $display("FAIL run_ram got we=%b addr=%0d exp 0 5", ram_wr_en, ram_addr); end
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 8'h00) begin errors++; $display("FAIL clear_read got rvalid=%b rdata=%h exp 1 00", a_rvalid, a_rdata); end
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL clear_read_b got b_rvalid=%b exp 0", b_rvalid); end
    tick();
  endtask

  task automatic test_write_read;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 6'd10; a_wdata = 8'h3C;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1 || ram_wr_en !== 1'b1 || ram_addr !== 6'd10 || ram_din !== 8'h3C) begin errors++; $display("FAIL wr_grant got rdy=%b we=%b addr=%0d din=%h exp 1 1 10 3c", a_ready, ram_wr_en, ram_addr, ram_din); end
    tick();
    a_valid = 1'b0; a_we = 1'b0; b_valid = 1'b1; b_we = 1'b0; b_addr = 6'd10;
    @(negedge clk);
    checks++; if (b_ready !== 1'b1 || a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_grant got b_ready=%b a_rvalid=%b exp 1 0", b_ready, a_rvalid); end
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 8'h3C || a_rvalid !== 1'b0) begin errors++; $display("FAIL wr_then_rd got b_rvalid=%b b_rdata=%h a_rvalid=%b exp 1 3c 0", b_rvalid, b_rdata, a_rvalid); end
    tick();
  endtask

  task automatic test_alternate;
    // Seed addr1 via A and addr2 via B; round-robin then favours A again.
    a_valid = 1'b1; a_we = 1'b1; a_addr = 6'd1; a_wdata = 8'h11;
    tick();
    a_valid = 1'b0; b_valid = 1'b1; b_we = 1'b1; b_addr = 6'd2; b_wdata = 8'h22;
    tick();
    a_valid = 1'b1; a_we = 1'b0; b_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin a_valid = 1'b0; b_valid = 1'b0; end
      @(negedge clk);
      if (k < 4) begin
        checks++; if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin errors++; $display("FAIL alt_grant[%0d] got a=%b b=%b exp %b %b", k, a_ready, b_ready, k % 2 == 0, k % 2 == 1); end
      end
      if (k > 0) begin
        if (k % 2 == 1) begin
          checks++; if (a_rvalid !== 1'b1 || a_rdata !== 8'h11 || b_rvalid !== 1'b0) begin errors++; $display("FAIL alt_ret[%0d] got a_rv=%b a_rd=%h b_rv=%b exp 1 11 0", k, a_rvalid, a_rdata, b_rvalid); end
        end else begin
          checks++; if (b_rvalid !== 1'b1 || b_rdata !== 8'h22 || a_rvalid !== 1'b0) begin errors++; $display("FAIL alt_ret[%0d] got b_rv=%b b_rd=%h a_rv=%b exp 1 22 0", k, b_rvalid, b_rdata, a_rvalid); end
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] addrs [3];
    logic [7:0] exp_d [3];
    addrs[0] = 6'd1; addrs[1] = 6'd2; addrs[2] = 6'd10;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h3C;
    b_valid = 1'b1; b_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) b_addr = addrs[k]; else b_valid = 1'b0;
      @(negedge clk);
      if (k < 3) begin
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, b_ready); end
      end
      if (k > 0) begin
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== exp_d[k-1] || a_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_ret[%0d] got rv=%b rd=%h a_rv=%b exp 1 %h 0", k, b_rvalid, b_rdata, a_rvalid, exp_d[k-1]); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 6'd10;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_grant got %b exp 1", a_ready); end
    tick();
    a_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 8'h00) begin errors++; $display("FAIL mid_drop got rv=%b rd=%h exp 0 00", a_rvalid, a_rdata); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ram_wr_en !== 1'b1 || ram_addr !== 6'd0) begin errors++; $display("FAIL mid_clear0 got busy=%b we=%b addr=%0d exp 1 1 0", busy, ram_wr_en, ram_addr); end
    tick();
    @(negedge clk);
    checks++; if (ram_addr !== 6'd1) begin errors++; $display("FAIL mid_clear1 got addr=%0d exp 1", ram_addr); end
    repeat (63) tick();
    a_valid = 1'b1; a_addr = 6'd10;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || a_ready !== 1'b1) begin errors++; $display("FAIL mid_run got busy=%b rdy=%b exp 0 1", busy, a_ready); end
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 8'h00) begin errors++; $display("FAIL mid_recleared got rv=%b rd=%h exp 1 00", a_rvalid, a_rdata); end
    tick();
  endtask

`ifdef SPRAM_ARB_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (a_gnt_cnt !== 16'd0 || b_gnt_cnt !== 16'd0 || conflict_cnt !== 16'd0) begin errors++; $display("FAIL stats_rst got %0d %0d %0d exp 0 0 0", a_gnt_cnt, b_gnt_cnt, conflict_cnt); end
    tick();
    rst = 1'b0;
    repeat (64) tick();
    a_valid = 1'b1; a_we = 1'b0; a_addr = 6'd3; b_valid = 1'b1; b_we = 1'b0; b_addr = 6'd4;
    repeat (5) tick();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    checks++; if (conflict_cnt !== 16'd5) begin errors++; $display("FAIL stats_conflict got %0d exp 5", conflict_cnt); end
    checks++; if (a_gnt_cnt !== 16'd3 || b_gnt_cnt !== 16'd2) begin errors++; $display("FAIL stats_gnt got a=%0d b=%0d exp 3 2", a_gnt_cnt, b_gnt_cnt); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_clear_then_read();
    test_write_read();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
`ifdef SPRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of one single-port RAM configured for "No_change" mode (depth x width, 1-cycle registered read).
- Serialises read/write requests from ports A and B onto the single RAM port and returns read data with a per-port valid.
- Optionally clears the whole RAM after reset before accepting traffic.
- Sits between two client engines and the shared RAM instance.

Parameters:
- depth, 64, RAM word count; power of two, at least 2.
- width, 8, data word width.
- clear_on_rst, 1: 1 = zero-fill the RAM after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- a_valid  in  1  port A request present.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  $clog2(depth)  port A address.
- a_wdata  in  width  port A write data.
- a_ready  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  width  port A read data.
- b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as port A, for port B.
- ram_wr_en  out  1  to RAM wr_en.
- ram_addr  out  $clog2(depth)  to RAM addr.
- ram_din  out  width  to RAM data_in.
- ram_dout  in  width  from RAM data_out.
- busy  out  1  clear sequence in progress.

Behaviour:
- FSM states: CLEAR and RUN.
  - On rst: go to CLEAR if clear_on_rst=1, else RUN.
  - clr_cnt <= 0, rr_ptr <= A, rd_tag_v <= 0.
- CLEAR:
  - busy=1; a_ready=b_ready=0.
  - ram_wr_en=1, ram_addr=clr_cnt, ram_din=0.
  - clr_cnt increments each cycle.
  - When clr_cnt = depth-1, that write completes and the FSM moves to RUN on the next edge. CLEAR lasts exactly depth cycles.
- RUN, busy=0. Each cycle at most one request is granted, selected combinationally:
  - Only one port valid: that port wins.
  - Both valid: the port equal to rr_ptr wins.
  - Winner gets ready=1 in the same cycle; the loser's ready=0.
  - Handshake completes when valid & ready are both 1.
  - The requester must hold valid, we, addr and wdata stable until ready.
- RAM drive on a grant: ram_wr_en=winner_we, ram_addr=winner_addr, ram_din=winner_wdata.
- RAM drive with no grant: ram_wr_en=0, ram_addr and ram_din hold their last values. A no-grant idle cycle still performs a RAM read that nobody consumes; this is harmless.
- rr_ptr updates only on a grant, to the port that did not win. A lone requester may win on back-to-back cycles.
- Read return:
  - A read granted in cycle N raises the owner's rvalid for exactly cycle N+1, with rdata = ram_dout.
  - Tracked by registers rd_tag_v and rd_tag_port.
  - Reads may be issued back to back; every cycle can return one read.
  - Write grants never raise rvalid.
  - When rvalid=0, rdata=0.
- Ordering: a write to address X in cycle N followed by a read of X in cycle N+1 (either port) returns the new value.
- Reset mid-operation: a pending read return is dropped (rvalid=0 next cycle). CLEAR restarts from address 0.
- Reset values: a_ready=b_ready=0, a_rvalid=b_rvalid=0, rdata=0, ram_wr_en=0, ram_addr=0, ram_din=0. busy=1 if clear_on_rst=1, else 0.

Optional Feature:
- Macro: SPRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs a_gnt_cnt, b_gnt_cnt and conflict_cnt, each 16 bits, saturating, cleared by rst.
  - The grant counters increment on each handshake of their port.
  - conflict_cnt increments on each RUN cycle where a_valid and b_valid are both 1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- clear_on_rst=1, depth=64; assert rst 2 cycles, release -> busy=1 for 64 cycles, ready stays 0, ram_wr_en=1 with addr 0..63. Then read addr 5 on A -> a_rvalid next cycle, a_rdata=0x00.
- RUN; A writes 0x3C to addr 10 (cycle N), B reads addr 10 (cycle N+1) -> b_rvalid at N+2 with b_rdata=0x3C; a_rvalid never asserts.
- A and B both hold valid reads (A addr 1, B addr 2) for 4 cycles after reset -> grants alternate A,B,A,B; rvalid alternates the cycle after each grant.
- Only B valid for 3 consecutive reads -> b_ready=1 on all 3 cycles; b_rvalid=1 on 3 consecutive cycles with the matching data.
- A read is granted, then rst is asserted in the next cycle -> a_rvalid=0; CLEAR restarts with ram_addr=0.
- With SPRAM_ARB_STATS_EN: 5 contended cycles -> conflict_cnt=5, a_gnt_cnt+b_gnt_cnt=5, each between 2 and 3.
